// File: rtl/modulo_ctrl.sv
// Sequencer for the modulo datapath: computes a_i mod b_i by repeated compare/subtract
// through an external combinational ALU. Optional quotient output under MODULO_QUOT_EN.
module modulo_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             div_zero_o,
    output logic [2:0]       alu_mode_o,
    output logic [WIDTH-1:0] alu_op_a_o,
    output logic [WIDTH-1:0] alu_op_b_o,
    input  logic [WIDTH-1:0] alu_res_i
`ifdef MODULO_QUOT_EN
    ,
    output logic [WIDTH-1:0] quot_o
`endif
);

    localparam logic [2:0] MODE_CMP  = 3'd0;
    localparam logic [2:0] MODE_DIFF = 3'd1;
    localparam logic [2:0] MODE_IDLE = 3'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        SUB  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] div_q;
    logic             div_is_zero;

`ifdef MODULO_QUOT_EN
    logic [WIDTH-1:0] quot_q;
`endif

    assign div_is_zero = (div_q == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the ALU is combinational so its result steers this cycle's decision
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (b_i == '0) ? DONE : CMP;
                end
            end
            CMP:     state_d = (alu_res_i == '0) ? SUB : DONE;
            SUB:     state_d = CMP;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore output decode
    always_comb begin
        ready_o    = 1'b0;
        done_o     = 1'b0;
        alu_mode_o = MODE_IDLE;
        alu_op_a_o = '0;
        alu_op_b_o = '0;
        case (state_q)
            IDLE: ready_o = 1'b1;
            CMP: begin
                alu_mode_o = MODE_CMP;
                alu_op_a_o = rem_q;
                alu_op_b_o = div_q;
            end
            SUB: begin
                alu_mode_o = MODE_DIFF;
                alu_op_a_o = rem_q;
                alu_op_b_o = div_q;
            end
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

    // Operand, remainder and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q      <= '0;
            div_q      <= '0;
            result_o   <= '0;
            div_zero_o <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        rem_q <= a_i;
                        div_q <= b_i;
                    end
                end
                SUB: rem_q <= alu_res_i;
                DONE: begin
                    result_o   <= div_is_zero ? '0 : rem_q;
                    div_zero_o <= div_is_zero;
                end
                default: ;
            endcase
        end
    end

`ifdef MODULO_QUOT_EN
    // Quotient counts subtract steps; a zero divisor never subtracts so it stays 0
    always_ff @(posedge clk) begin
        if (rst) begin
            quot_q <= '0;
            quot_o <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        quot_q <= '0;
                    end
                end
                SUB:  quot_q <= quot_q + WIDTH'(1);
                DONE: quot_o <= div_is_zero ? '0 : quot_q;
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_modulo_ctrl.sv
// Directed testbench for modulo_ctrl with a behavioural combinational ALU.
// Quotient checks are compiled in when MODULO_QUOT_EN is defined.
module tb_modulo_ctrl;

    localparam int unsigned WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             ready_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic             div_zero_o;
    logic [2:0]       alu_mode_o;
    logic [WIDTH-1:0] alu_op_a_o;
    logic [WIDTH-1:0] alu_op_b_o;
    logic [WIDTH-1:0] alu_res_i;
`ifdef MODULO_QUOT_EN
    logic [WIDTH-1:0] quot_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    modulo_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .ready_o    (ready_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .div_zero_o (div_zero_o),
        .alu_mode_o (alu_mode_o),
        .alu_op_a_o (alu_op_a_o),
        .alu_op_b_o (alu_op_b_o),
        .alu_res_i  (alu_res_i)
`ifdef MODULO_QUOT_EN
        ,
        .quot_o     (quot_o)
`endif
    );

    always #5 clk = ~clk;

    // Environment ALU: compare gives 0 when A>=B, diff gives A-B
    always_comb begin
        alu_res_i = '0;
        if (alu_mode_o == 3'd0) alu_res_i = (alu_op_a_o >= alu_op_b_o) ? '0 : WIDTH'(1);
        else if (alu_mode_o == 3'd1) alu_res_i = alu_op_a_o - alu_op_b_o;
    end

    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        start_i = 1'b1;
        a_i     = a;
        b_i     = b;
    endtask

    // Counts edges from the accepting edge until done_o is seen, plus diff-mode cycles
    task automatic wait_done(input int budget, output int cyc, output int subs, output bit hit);
        cyc  = 0;
        subs = 0;
        hit  = 1'b0;
        while (!hit && cyc < budget) begin
            @(posedge clk);
            #1;
            start_i = 1'b0;
            cyc++;
            if (alu_mode_o == 3'd1) subs++;
            if (done_o) hit = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; a_i = '0; b_i = '0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL rst_ready got %0b want 1", ready_o); end
        n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL rst_done got %0b want 0", done_o); end
        n_vec++; if (alu_mode_o !== 3'd2) begin n_err++; $display("FAIL rst_mode got %0d want 2", alu_mode_o); end
        n_vec++; if (alu_op_a_o !== '0 || alu_op_b_o !== '0) begin n_err++; $display("FAIL rst_ops got %0d/%0d want 0/0", alu_op_a_o, alu_op_b_o); end
        n_vec++; if (result_o !== '0 || div_zero_o !== 1'b0) begin n_err++; $display("FAIL rst_result got %0d dz %0b want 0 dz 0", result_o, div_zero_o); end
`ifdef MODULO_QUOT_EN
        n_vec++; if (quot_o !== '0) begin n_err++; $display("FAIL rst_quot got %0d want 0", quot_o); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int cyc, subs; bit hit;
        start_op(16'd17, 16'd5);
        wait_done(40, cyc, subs, hit);
        n_vec++; if (hit !== 1'b1 || cyc != 8) begin n_err++; $display("FAIL basic_latency got %0d hit %0b want 8", cyc, hit); end
        n_vec++; if (subs != 3) begin n_err++; $display("FAIL basic_subs got %0d want 3", subs); end
        @(posedge clk); #1;
        n_vec++; if (result_o !== 16'd2 || div_zero_o !== 1'b0) begin n_err++; $display("FAIL basic_result got %0d dz %0b want 2 dz 0", result_o, div_zero_o); end
        n_vec++; if (ready_o !== 1'b1 || done_o !== 1'b0) begin n_err++; $display("FAIL basic_idle got ready %0b done %0b want 1 0", ready_o, done_o); end
`ifdef MODULO_QUOT_EN
        n_vec++; if (quot_o !== 16'd3) begin n_err++; $display("FAIL basic_quot got %0d want 3", quot_o); end
`endif
    endtask

    task automatic test_a_lt_b();
        int cyc, subs; bit hit;
        start_op(16'd3, 16'd7);
        wait_done(40, cyc, subs, hit);
        n_vec++; if (hit !== 1'b1 || cyc != 2) begin n_err++; $display("FAIL altb_latency got %0d hit %0b want 2", cyc, hit); end
        n_vec++; if (subs != 0) begin n_err++; $display("FAIL altb_diff_cycles got %0d want 0", subs); end
        @(posedge clk); #1;
        n_vec++; if (result_o !== 16'd3 || div_zero_o !== 1'b0) begin n_err++; $display("FAIL altb_result got %0d dz %0b want 3 dz 0", result_o, div_zero_o); end
`ifdef MODULO_QUOT_EN
        n_vec++; if (quot_o !== 16'd0) begin n_err++; $display("FAIL altb_quot got %0d want 0", quot_o); end
`endif
    endtask

    task automatic test_div_zero();
        int cyc, subs; bit hit;
        start_op(16'd9, 16'd0);
        wait_done(40, cyc, subs, hit);
        n_vec++; if (hit !== 1'b1 || cyc != 1) begin n_err++; $display("FAIL dz_latency got %0d hit %0b want 1", cyc, hit); end
        n_vec++; if (alu_mode_o !== 3'd2 || subs != 0) begin n_err++; $display("FAIL dz_mode got %0d subs %0d want 2 subs 0", alu_mode_o, subs); end
        @(posedge clk); #1;
        n_vec++; if (result_o !== '0 || div_zero_o !== 1'b1) begin n_err++; $display("FAIL dz_result got %0d dz %0b want 0 dz 1", result_o, div_zero_o); end
`ifdef MODULO_QUOT_EN
        n_vec++; if (quot_o !== 16'd0) begin n_err++; $display("FAIL dz_quot got %0d want 0", quot_o); end
`endif
    endtask

    task automatic test_bounds();
        int cyc, subs; bit hit;
        start_op(16'd7, 16'd7);
        wait_done(40, cyc, subs, hit);
        n_vec++; if (hit !== 1'b1 || cyc != 4) begin n_err++; $display("FAIL aeqb_latency got %0d hit %0b want 4", cyc, hit); end
        @(posedge clk); #1;
        n_vec++; if (result_o !== '0 || div_zero_o !== 1'b0) begin n_err++; $display("FAIL aeqb_result got %0d dz %0b want 0 dz 0", result_o, div_zero_o); end
`ifdef MODULO_QUOT_EN
        n_vec++; if (quot_o !== 16'd1) begin n_err++; $display("FAIL aeqb_quot got %0d want 1", quot_o); end
`endif
        start_op(16'd0, 16'd5);
        wait_done(40, cyc, subs, hit);
        n_vec++; if (hit !== 1'b1 || cyc != 2) begin n_err++; $display("FAIL azero_latency got %0d hit %0b want 2", cyc, hit); end
        @(posedge clk); #1;
        n_vec++; if (result_o !== '0) begin n_err++; $display("FAIL azero_result got %0d want 0", result_o); end
        start_op(16'd65535, 16'd40000);
        wait_done(40, cyc, subs, hit);
        n_vec++; if (hit !== 1'b1 || cyc != 4) begin n_err++; $display("FAIL max_latency got %0d hit %0b want 4", cyc, hit); end
        @(posedge clk); #1;
        n_vec++; if (result_o !== 16'd25535) begin n_err++; $display("FAIL max_result got %0d want 25535", result_o); end
    endtask

    task automatic test_long_ignore_start();
        int cyc = 0;
        int subs = 0;
        bit hit = 1'b0;
        start_op(16'd100, 16'd1);
        while (!hit && cyc < 400) begin
            @(posedge clk);
            #1;
            start_i = 1'b0;
            cyc++;
            if (alu_mode_o == 3'd1) subs++;
            if (done_o) hit = 1'b1;
            if (cyc == 10) start_op(16'd5, 16'd2);
        end
        n_vec++; if (hit !== 1'b1 || cyc != 202) begin n_err++; $display("FAIL long_latency got %0d hit %0b want 202", cyc, hit); end
        n_vec++; if (subs != 100) begin n_err++; $display("FAIL long_subs got %0d want 100", subs); end
        @(posedge clk); #1;
        n_vec++; if (result_o !== '0 || div_zero_o !== 1'b0) begin n_err++; $display("FAIL long_result got %0d dz %0b want 0 dz 0", result_o, div_zero_o); end
`ifdef MODULO_QUOT_EN
        n_vec++; if (quot_o !== 16'd100) begin n_err++; $display("FAIL long_quot got %0d want 100", quot_o); end
`endif
    endtask

    task automatic test_reset_abort();
        int dones = 0;
        start_op(16'd50, 16'd7);
        repeat (4) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            if (done_o) dones++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (ready_o !== 1'b1 || alu_mode_o !== 3'd2) begin n_err++; $display("FAIL abort_state got ready %0b mode %0d want 1 2", ready_o, alu_mode_o); end
        n_vec++; if (result_o !== '0) begin n_err++; $display("FAIL abort_result got %0d want 0", result_o); end
        rst = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done_o) dones++;
        end
        n_vec++; if (dones != 0 || ready_o !== 1'b1) begin n_err++; $display("FAIL abort_no_done got %0d pulses ready %0b want 0 ready 1", dones, ready_o); end
    endtask

    task automatic test_back_to_back();
        int cyc, subs; bit hit;
        start_op(16'd20, 16'd6);
        wait_done(40, cyc, subs, hit);
        n_vec++; if (hit !== 1'b1 || cyc != 8) begin n_err++; $display("FAIL b2b1_latency got %0d hit %0b want 8", cyc, hit); end
        @(posedge clk); #1;
        n_vec++; if (result_o !== 16'd2 || ready_o !== 1'b1) begin n_err++; $display("FAIL b2b1_result got %0d ready %0b want 2 ready 1", result_o, ready_o); end
        start_op(16'd6, 16'd6);
        @(posedge clk); #1;
        start_i = 1'b0;
        n_vec++; if (result_o !== 16'd2 || ready_o !== 1'b0) begin n_err++; $display("FAIL b2b_hold got %0d ready %0b want 2 ready 0", result_o, ready_o); end
        wait_done(40, cyc, subs, hit);
        n_vec++; if (hit !== 1'b1 || cyc != 3) begin n_err++; $display("FAIL b2b2_latency got %0d hit %0b want 3 more", cyc, hit); end
        n_vec++; if (result_o !== 16'd2) begin n_err++; $display("FAIL b2b_hold_at_done got %0d want 2", result_o); end
        @(posedge clk); #1;
        n_vec++; if (result_o !== '0 || div_zero_o !== 1'b0) begin n_err++; $display("FAIL b2b2_result got %0d dz %0b want 0 dz 0", result_o, div_zero_o); end
`ifdef MODULO_QUOT_EN
        n_vec++; if (quot_o !== 16'd1) begin n_err++; $display("FAIL b2b2_quot got %0d want 1", quot_o); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_a_lt_b();
        test_div_zero();
        test_bounds();
        test_long_ignore_start();
        test_basic();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
